// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions for the fetch/redirect stage: next-PC select
// encodings, the bubble instruction and the fetch control states.
package rv_pipe_pkg;

   localparam logic [3:0]  PCSEL_PC4  = 4'd0;
   localparam logic [3:0]  PCSEL_PRED = 4'd1;
   localparam logic [3:0]  PCSEL_BR   = 4'd5;

   localparam logic [31:0] NOP_INST   = 32'h0000_0013;
   localparam logic [6:0]  OPC_BRANCH = 7'b110_0011;

   typedef enum logic [1:0] {
      ST_WARM  = 2'd0,
      ST_RUN   = 2'd1,
      ST_REDIR = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC select: sequential PC+4, predicted target, or the
// execute-stage correction, which overrides everything else.
module next_pc_mux (
   input  logic [31:0] pc,
   input  logic [3:0]  pcmux_sel,
   input  logic        predict_fail,
   input  logic [31:0] target_F,
   input  logic [31:0] target_X,
   output logic [31:0] next_pc
);
   import rv_pipe_pkg::*;

   function automatic logic [31:0] pc_plus4(input logic [31:0] p);
      return p + 32'd4;
   endfunction

   // A correction select without a live mispredict falls back to PC+4.
   always_comb begin
      next_pc = pc_plus4(pc);
      if (predict_fail) begin
         next_pc = target_X;
      end else if (pcmux_sel == PCSEL_PRED) begin
         next_pc = target_F;
      end
   end

endmodule

// File: rtl/fetch_redirect_stage.sv
// Fetch PC register and IF/ID register with mispredict redirect, stall hold,
// reset warm-up bubble and a saturating mispredict counter.
module fetch_redirect_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       pcmux_sel,
   input  logic             predict_fail,
   input  logic             stall,
   input  logic [31:0]      target_F,
   input  logic [31:0]      target_X,
   input  logic [31:0]      imem_inst,
   output logic [31:0]      pc_F,
   output logic [31:0]      pc_D,
   output logic [31:0]      inst_D,
   output logic             valid_D,
   output logic             flush_E,
   output logic [CNT_W-1:0] mispredict_cnt
);
   import rv_pipe_pkg::*;

   fetch_state_e state_q;
   fetch_state_e state_d;
   logic         redirect;
   logic         advance;
   logic [31:0]  next_pc;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   next_pc_mux u_next_pc_mux (
      .pc           (pc_F),
      .pcmux_sel    (pcmux_sel),
      .predict_fail (predict_fail),
      .target_F     (target_F),
      .target_X     (target_X),
      .next_pc      (next_pc)
   );

   // RUN and REDIR behave alike; REDIR only marks the cycle after a redirect.
   always_comb begin
      state_d  = state_q;
      redirect = 1'b0;
      advance  = 1'b0;
      case (state_q)
         ST_WARM: state_d = ST_RUN;
         ST_RUN, ST_REDIR: begin
            redirect = predict_fail;
            advance  = !predict_fail && !stall;
            state_d  = predict_fail ? ST_REDIR : ST_RUN;
         end
         default: state_d = ST_WARM;
      endcase
   end

   assign flush_E = redirect;

   // Fetch -> Decode boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_WARM;
         pc_F           <= RESET_PC;
         pc_D           <= 32'h0000_0000;
         inst_D         <= NOP_INST;
         valid_D        <= 1'b0;
         mispredict_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (redirect || advance) begin
            pc_F <= next_pc;
         end
         if ((state_q == ST_WARM) || redirect) begin
            inst_D  <= NOP_INST;
            valid_D <= 1'b0;
         end else if (advance) begin
            pc_D    <= pc_F;
            inst_D  <= imem_inst;
            valid_D <= 1'b1;
         end
         if (redirect) begin
            mispredict_cnt <= sat_inc(mispredict_cnt);
         end
      end
   end

endmodule
